// File: rtl/csa_final_adder_pkg.sv
// Shared constants and types for the segmented carry-propagate final adder.
package csa_pkg;

    localparam int CSA_WIDTH = 64;
    localparam int CSA_SEG   = 16;

    // One slice result: SEG sum bits plus the carry out of that slice.
    typedef struct packed {
        logic [CSA_SEG-1:0] s;
        logic               c;
    } csa_slice_t;

    // Number of pipeline stages (and latency) for a given width/slice split.
    function automatic int nstg(input int width, input int seg);
        return width / seg;
    endfunction

endpackage

// File: rtl/csa_final_adder_if.sv
// Valid/ready bus carrying the two redundant rows in and the binary sum out.
interface csa_final_adder_if
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             cout;

    // Producer/consumer side (drives operands, accepts results).
    modport master (
        output in_valid, A, B, cin, out_ready,
        input  in_ready, out_valid, S, cout
    );

    // Adder side.
    modport slave (
        input  in_valid, A, B, cin, out_ready,
        output in_ready, out_valid, S, cout
    );
endinterface

// File: rtl/csa_final_adder_seg_stage.sv
// One SEG-bit slice of the carry chain with its registered valid, sum and carry.
module csa_seg_stage #(
    parameter int SEG = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           adv,
    input  logic           v_in,
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           c_in,
    output logic           v_q,
    output logic [SEG-1:0] s_q,
    output logic           c_q
);
    logic [SEG:0]   sum;
    logic           v_d;
    logic [SEG-1:0] s_d;
    logic           c_d;

    // Slice add and hold-unless-advancing next-state selection.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c_in};
        v_d = v_q;
        s_d = s_q;
        c_d = c_q;
        if (adv) begin
            v_d = v_in;
            s_d = sum[SEG-1:0];
            c_d = sum[SEG];
        end
    end

    // Stage register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= 1'b0;
            s_q <= '0;
            c_q <= 1'b0;
        end else begin
            v_q <= v_d;
            s_q <= s_d;
            c_q <= c_d;
        end
    end
endmodule

// File: rtl/csa_final_adder.sv
// Segmented final carry-propagate adder: slice k adds in stage k, operands are
// skewed in by k stages and results deskewed out so a whole word lands together.
module csa_final_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int SEG   = CSA_SEG
) (
    input logic              clk,
    input logic              rst,
    csa_final_adder_if.slave bus
);
    localparam int NSTG = nstg(WIDTH, SEG);

    if ((WIDTH % SEG) != 0 || WIDTH < SEG) begin : g_bad_cfg
        $error("csa_final_adder: WIDTH must be a non-zero multiple of SEG");
    end

    logic                      adv;
    logic [NSTG-1:0][SEG-1:0]  a_stg;
    logic [NSTG-1:0][SEG-1:0]  b_stg;
    logic [NSTG-1:0][SEG-1:0]  s_stg;
    logic [NSTG-1:0][SEG-1:0]  s_out;
    logic [NSTG-1:0]           v_stg;
    logic [NSTG-1:0]           c_stg;

    // Whole pipeline moves together; it only stalls when a result is stuck.
    assign adv           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = v_stg[NSTG-1];
    assign bus.cout      = c_stg[NSTG-1];
    assign bus.S         = s_out;

    for (genvar k = 0; k < NSTG; k++) begin : g_slice
        localparam int DSK = NSTG - 1 - k;

        if (k == 0) begin : g_noskew
            assign a_stg[0] = bus.A[SEG-1:0];
            assign b_stg[0] = bus.B[SEG-1:0];
        end else begin : g_skew
            logic [SEG-1:0] a_skew_q [k];
            logic [SEG-1:0] a_skew_d [k];
            logic [SEG-1:0] b_skew_q [k];
            logic [SEG-1:0] b_skew_d [k];

            // Delay operand slice k by k stages so it meets the incoming carry.
            always_comb begin
                a_skew_d = a_skew_q;
                b_skew_d = b_skew_q;
                if (adv) begin
                    a_skew_d[0] = bus.A[k*SEG +: SEG];
                    b_skew_d[0] = bus.B[k*SEG +: SEG];
                    for (int j = 1; j < k; j++) begin
                        a_skew_d[j] = a_skew_q[j-1];
                        b_skew_d[j] = b_skew_q[j-1];
                    end
                end
            end

            // Skew shift registers.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < k; j++) begin
                        a_skew_q[j] <= '0;
                        b_skew_q[j] <= '0;
                    end
                end else begin
                    a_skew_q <= a_skew_d;
                    b_skew_q <= b_skew_d;
                end
            end

            assign a_stg[k] = a_skew_q[k-1];
            assign b_stg[k] = b_skew_q[k-1];
        end

        csa_seg_stage #(.SEG(SEG)) u_stage (
            .clk  (clk),
            .rst  (rst),
            .adv  (adv),
            .v_in ((k == 0) ? bus.in_valid : v_stg[(k == 0) ? 0 : k-1]),
            .a    (a_stg[k]),
            .b    (b_stg[k]),
            .c_in ((k == 0) ? bus.cin : c_stg[(k == 0) ? 0 : k-1]),
            .v_q  (v_stg[k]),
            .s_q  (s_stg[k]),
            .c_q  (c_stg[k])
        );

        if (DSK == 0) begin : g_nodeskew
            assign s_out[k] = s_stg[k];
        end else begin : g_deskew
            logic [SEG-1:0] dsk_q [DSK];
            logic [SEG-1:0] dsk_d [DSK];

            // Hold finished slice k until the top slice of the same word is done.
            always_comb begin
                dsk_d = dsk_q;
                if (adv) begin
                    dsk_d[0] = s_stg[k];
                    for (int j = 1; j < DSK; j++) begin
                        dsk_d[j] = dsk_q[j-1];
                    end
                end
            end

            // Deskew shift registers.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < DSK; j++) begin
                        dsk_q[j] <= '0;
                    end
                end else begin
                    dsk_q <= dsk_d;
                end
            end

            assign s_out[k] = dsk_q[DSK-1];
        end
    end
endmodule

// File: tb/tb_csa_final_adder.sv
// Directed bench for the segmented final adder (64/16 and degenerate 16/16).
module tb_csa_final_adder;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] s;
        logic        cout;
    } vec_t;

    typedef struct {
        logic [63:0] s;
        logic        cout;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csa_final_adder_if #(.WIDTH(64)) if64 ();
    csa_final_adder_if #(.WIDTH(16)) if16 ();

    csa_final_adder #(.WIDTH(64), .SEG(16)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));
    csa_final_adder #(.WIDTH(16), .SEG(16)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q64[$];
    exp_t q16[$];
    exp_t pend64;
    exp_t pend16;
    bit   acc64;
    bit   acc16;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {64'd0, cin};
    endfunction

    // One clock: scoreboard outputs and record accepts at negedge, then advance.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (if64.out_valid === 1'b1) begin
            if (q64.size() == 0) begin
                checks++; errors++;
                $display("FAIL out64_spurious actual=valid required=no_pending");
            end else begin
                e = q64[0];
                chk("S64", if64.S, e.s);
                chk("cout64", 64'(if64.cout), 64'(e.cout));
                if (if64.out_ready) begin
                    if (e.chk_lat) chk("lat64", 64'(cyc - e.acc_cyc), 64'd4);
                    void'(q64.pop_front());
                end
            end
        end
        if (if16.out_valid === 1'b1) begin
            if (q16.size() == 0) begin
                checks++; errors++;
                $display("FAIL out16_spurious actual=valid required=no_pending");
            end else begin
                e = q16[0];
                chk("S16", 64'(if16.S), e.s);
                chk("cout16", 64'(if16.cout), 64'(e.cout));
                if (if16.out_ready) begin
                    if (e.chk_lat) chk("lat16", 64'(cyc - e.acc_cyc), 64'd1);
                    void'(q16.pop_front());
                end
            end
        end
        if (if64.in_valid && if64.in_ready) begin
            pend64.acc_cyc = cyc;
            q64.push_back(pend64);
            acc64 = 1'b1;
        end
        if (if16.in_valid && if16.in_ready) begin
            pend16.acc_cyc = cyc;
            q16.push_back(pend16);
            acc16 = 1'b1;
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send64(input logic [63:0] a, input logic [63:0] b, input logic cin,
                          input logic [63:0] s, input logic cout, input bit chk_lat);
        if64.A = a; if64.B = b; if64.cin = cin; if64.in_valid = 1'b1;
        pend64.s = s; pend64.cout = cout; pend64.chk_lat = chk_lat;
        acc64 = 1'b0;
        for (int i = 0; i < 50 && !acc64; i++) step();
        if (!acc64) begin
            checks++; errors++;
            $display("FAIL accept64_timeout actual=not_accepted required=accepted");
        end
        if64.in_valid = 1'b0;
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [15:0] s, input logic cout);
        if16.A = a; if16.B = b; if16.cin = cin; if16.in_valid = 1'b1;
        pend16.s = {48'd0, s}; pend16.cout = cout; pend16.chk_lat = 1'b1;
        acc16 = 1'b0;
        for (int i = 0; i < 50 && !acc16; i++) step();
        if (!acc16) begin
            checks++; errors++;
            $display("FAIL accept16_timeout actual=not_accepted required=accepted");
        end
        if16.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q64.size() != 0 || q16.size() != 0); i++) step();
        if (q64.size() != 0 || q16.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d/%0d pending required=0/0", q64.size(), q16.size());
        end
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [64:0] r;
        logic [63:0] a;
        logic [63:0] b;
        logic        c;

        rst = 1'b1;
        if64.in_valid = 1'b0; if64.A = '0; if64.B = '0; if64.cin = 1'b0; if64.out_ready = 1'b1;
        if16.in_valid = 1'b0; if16.A = '0; if16.B = '0; if16.cin = 1'b0; if16.out_ready = 1'b1;

        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1};
        tbl[1] = '{64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 64'h0000_0001_0000_0000, 1'b0};
        tbl[2] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0};
        tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        tbl[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1};
        tbl[5] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0};
        tbl[6] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h2222_2222_2222_2211, 1'b0};
        tbl[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h8000_0000_0000_0000, 1'b0};
        tbl[8] = '{64'h0000_FFFF_0000_FFFF, 64'h1, 1'b0, 64'h0000_FFFF_0001_0000, 1'b0};

        #12;
        chk("rst_out_valid", 64'(if64.out_valid), 64'd0);
        chk("rst_S", if64.S, 64'd0);
        chk("rst_cout", 64'(if64.cout), 64'd0);
        chk("rst_in_ready", 64'(if64.in_ready), 64'd1);
        chk("rst_out_valid16", 64'(if16.out_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 64'(if64.in_ready), 64'd1);

        // Hand vectors, streamed back to back with latency checked on each.
        for (int i = 0; i < 9; i++) begin
            send64(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].cout, 1'b1);
        end
        drain();

        // Eight random operands on consecutive cycles against the reference sum.
        for (int i = 0; i < 8; i++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = 1'($urandom_range(0, 1));
            r = ref_add(a, b, c);
            send64(a, b, c, r[63:0], r[64], 1'b1);
        end
        drain();

        // Backpressure: fill the pipe with the consumer stalled, hold, then release.
        if64.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = 1'(i % 2);
            r = ref_add(a, b, c);
            send64(a, b, c, r[63:0], r[64], 1'b0);
        end
        chk("bp_out_valid", 64'(if64.out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_in_ready", 64'(if64.in_ready), 64'd0);
            chk("bp_out_valid_hold", 64'(if64.out_valid), 64'd1);
        end
        if64.out_ready = 1'b1;
        drain();

        // Reset with three transactions in flight, one of them already presented.
        if64.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send64(64'(i + 100), 64'(i), 1'b0, 64'(2 * i + 100), 1'b0, 1'b0);
        end
        step();
        chk("pre_rst_out_valid", 64'(if64.out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(if64.out_valid), 64'd0);
        chk("midrst_S", if64.S, 64'd0);
        chk("midrst_cout", 64'(if64.cout), 64'd0);
        chk("midrst_in_ready", 64'(if64.in_ready), 64'd1);
        q64.delete();
        step();
        rst = 1'b0;
        if64.out_ready = 1'b1;
        send64(64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1'b1);
        drain();

        // Degenerate single-stage configuration.
        send16(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        send16(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        send16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        send16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        send16(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
